dict_codec: RTL and testbench
=============================

# dict_codec

Parametrised dictionary compression/decompression engine. COMPRESS maps a DATA_W-bit word to a dictionary index: it returns the existing index on a hit and allocates the next free entry on a miss. DECOMPRESS maps an index back to its stored word. The block uses a valid/ready command interface and a valid/ready response interface, and searches LANES entries per cycle. It replaces the fixed 80-bit/256-entry single-cycle codec in the datapath. An explicit fill counter provides occupancy, so all-zero data words are legal dictionary content.

## Interface
- DATA_W, 80: width of uncompressed words.
- DEPTH, 256: dictionary entries; power of two, at least 2.
- LANES, 4: entries compared per search cycle; power of two, divides DEPTH.
- IDX_W, $clog2(DEPTH): index width (derived, not overridden).

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd  in  2  00 CLEAR, 01 COMPRESS, 10 DECOMPRESS, 11 reserved.
- data_in  in  DATA_W  word to compress; sampled at accept.
- index_in  in  IDX_W  index to decompress; sampled at accept.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp  out  2  00 CLEARED, 01 COMPRESSED, 10 DECOMPRESSED, 11 ERROR.
- rsp_index  out  IDX_W  compressed index; 0 unless rsp=01.
- rsp_data  out  DATA_W  decompressed word; 0 unless rsp=10.
- rsp_hit  out  1  COMPRESS matched an existing entry.
- fill_count  out  IDX_W+1  number of valid entries, 0..DEPTH.

## Operation
- FSM states are IDLE, SEARCH and RESP. Accept occurs when cmd_valid && cmd_ready.
- Entries 0..fill_count-1 are valid and contiguous. There is no per-entry delete. Only CLEAR and reset free entries.
- CLEAR: sets fill_count to 0 and goes to RESP with rsp=00. Memory contents are not scrubbed.
- COMPRESS with fill_count=0: miss, handled directly in the accept cycle.
- COMPRESS with fill_count>0: go to SEARCH at group g=0. Each SEARCH cycle compares entries g*LANES .. g*LANES+LANES-1, masking entries at or above fill_count.
  - Hit: the lowest matching index wins. Go to RESP with rsp=01, rsp_hit=1, rsp_index=match.
  - Last group with no hit, fill_count<DEPTH: write data_in to entry fill_count and increment fill_count. Go to RESP with rsp=01, rsp_hit=0, rsp_index=old fill_count.
  - Last group with no hit, fill_count==DEPTH: go to RESP with rsp=11 and no write.
- DECOMPRESS: if index_in < fill_count, go to RESP with rsp=10 and rsp_data=mem[index_in]. Otherwise go to RESP with rsp=11.
- cmd=11: go to RESP with rsp=11.
- RESP: rsp_valid=1 and all rsp fields are held stable. On rsp_ready, return to IDLE.

## Timing
- Reset values: cmd_ready=0 while reset is asserted, then 1 (IDLE). rsp_valid=0, rsp=00, rsp_index=0, rsp_data=0, rsp_hit=0, fill_count=0.
- Edge numbering: E0 is the accept edge. Ek is k edges later.
- CLEAR, DECOMPRESS, reserved command, and COMPRESS with fill_count=0: rsp_valid high after E1.
- COMPRESS hit at index h: rsp_valid high after E(h/LANES + 1).
- COMPRESS miss: rsp_valid high after E(ceil(fill_count/LANES)).
- The dictionary write and fill_count update take effect on the same edge that raises rsp_valid.
- With rsp_ready tied high, each response lasts one cycle and cmd_ready rises the next cycle. This gives a one-cycle bubble between commands.
- rsp_valid is never dropped without rsp_ready.
- Back-to-back COMPRESS of the same new word: the first allocates an entry, and the second hits it.
- Reset mid-SEARCH or mid-RESP: the operation is aborted, no write occurs, and all outputs return to their reset values.

## Structure
- Package dict_codec_pkg: cmd_e, rsp_e, state_e enums.
- Sub-module dict_codec_match: combinational LANES-wide equality compare with valid mask and lowest-lane priority encode. Outputs hit and lane index.
- The memory is a plain array with no reset, so it can infer as RAM.

## Test plan
All scenarios use DATA_W=80, DEPTH=8, LANES=2.
- Reset, then DECOMPRESS index 0 -> rsp=11, fill_count=0.
- COMPRESS 80'h0 -> rsp=01, rsp_hit=0, rsp_index=0 at E1, fill_count=1. Then COMPRESS 80'h0 again -> rsp_hit=1, rsp_index=0.
- COMPRESS 8 distinct words A0..A7 -> indices 0..7, fill_count=8. COMPRESS a new word B -> rsp=11 after E4, fill_count stays 8. COMPRESS A7 -> hit, index 7, rsp_valid after E4.
- DECOMPRESS index 5 after the previous scenario -> rsp=10, rsp_data=A5. CLEAR -> rsp=00, fill_count=0. DECOMPRESS index 5 -> rsp=11.
- Hold rsp_ready=0 for 5 cycles during a response -> rsp fields stable, cmd_ready=0 throughout. A command presented during this time is not accepted.
- Assert reset during SEARCH for a COMPRESS of a new word at fill_count=6 -> rsp_valid=0, fill_count=0, no response is issued.

Source files
------------

// File: rtl/dict_codec_pkg.sv
// Shared types for the dictionary codec: command/response encodings and FSM states.
package dict_codec_pkg;

    typedef enum logic [1:0] {
        CMD_CLEAR      = 2'b00,
        CMD_COMPRESS   = 2'b01,
        CMD_DECOMPRESS = 2'b10,
        CMD_RSVD       = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        RSP_CLEARED      = 2'b00,
        RSP_COMPRESSED   = 2'b01,
        RSP_DECOMPRESSED = 2'b10,
        RSP_ERROR        = 2'b11
    } rsp_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SEARCH = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Width of a lane index; a single lane still gets one bit.
    function automatic int lane_bits(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/dict_codec_if.sv
// Command/response bus of the dictionary codec plus the occupancy status.
// Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready, and a
// response transfers where rsp_valid && rsp_ready; a raised valid and its payload are held until that edge.
interface dict_codec_if #(
    parameter int DATA_W = 80,
    parameter int IDX_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] data_in;
    logic [IDX_W-1:0]  index_in;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp;
    logic [IDX_W-1:0]  rsp_index;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_hit;
    logic [IDX_W:0]    fill_count;

    modport master (
        output cmd_valid, cmd, data_in, index_in, rsp_ready,
        input  cmd_ready, rsp_valid, rsp, rsp_index, rsp_data, rsp_hit, fill_count
    );

    modport slave (
        input  cmd_valid, cmd, data_in, index_in, rsp_ready,
        output cmd_ready, rsp_valid, rsp, rsp_index, rsp_data, rsp_hit, fill_count
    );
endinterface

// File: rtl/dict_codec_match.sv
// One search group: compares LANES stored words against the key and reports the
// lowest valid lane that matches.
module dict_codec_match #(
    parameter int DATA_W = 80,
    parameter int LANES  = 4,
    parameter int LANE_W = 2
) (
    input  logic [DATA_W-1:0]             key,
    input  logic [LANES-1:0][DATA_W-1:0]  words,
    input  logic [LANES-1:0]              valid,
    output logic                          hit,
    output logic [LANE_W-1:0]             lane
);
    // Scan from the top lane down so the lowest matching lane is written last.
    always_comb begin
        hit  = 1'b0;
        lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (valid[i] && (words[i] == key)) begin
                hit  = 1'b1;
                lane = LANE_W'(i);
            end
        end
    end
endmodule

// File: rtl/dict_codec.sv
// Dictionary compression/decompression engine: word->index with allocate-on-miss,
// index->word lookup, searching LANES entries per cycle.
module dict_codec
    import dict_codec_pkg::*;
#(
    parameter int DATA_W = 80,
    parameter int DEPTH  = 256,
    parameter int LANES  = 4
) (
    input  logic         clk,
    input  logic         reset,
    dict_codec_if.slave  bus,
    output state_e       dbg_state
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LANE_W = lane_bits(LANES);

    state_e            state;
    cmd_e              op;
    logic [DATA_W-1:0] key;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W:0]    base;
    logic [IDX_W:0]    fill;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    rsp_e              rsp_q;
    logic [IDX_W-1:0]  rsp_index_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_hit_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [LANES-1:0][DATA_W-1:0] lane_words;
    logic [LANES-1:0]             lane_valid;
    logic [IDX_W+1:0]             addr;
    logic                         hit;
    logic [LANE_W-1:0]            lane;
    logic                         last_group;
    logic                         full;
    logic [IDX_W-1:0]             match_addr;
    logic                         mem_we;

    // Entries at or above fill are masked so stale data left by CLEAR never matches.
    always_comb begin
        addr = '0;
        for (int i = 0; i < LANES; i++) begin
            addr          = {1'b0, base} + (IDX_W+2)'(i);
            lane_words[i] = mem[addr[IDX_W-1:0]];
            lane_valid[i] = addr < {1'b0, fill};
        end
    end

    dict_codec_match #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_match (
        .key   (key),
        .words (lane_words),
        .valid (lane_valid),
        .hit   (hit),
        .lane  (lane)
    );

    assign last_group = ({1'b0, base} + (IDX_W+2)'(LANES)) >= {1'b0, fill};
    assign full       = fill == (IDX_W+1)'(DEPTH);
    assign match_addr = base[IDX_W-1:0] + IDX_W'(lane);
    assign mem_we     = (state == ST_SEARCH) && (op == CMD_COMPRESS) && !hit && last_group && !full;

    always_ff @(posedge clk) begin
        if (mem_we) mem[fill[IDX_W-1:0]] <= key;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            op          <= CMD_CLEAR;
            key         <= '0;
            idx         <= '0;
            base        <= '0;
            fill        <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= RSP_CLEARED;
            rsp_index_q <= '0;
            rsp_data_q  <= '0;
            rsp_hit_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        op          <= cmd_e'(bus.cmd);
                        key         <= bus.data_in;
                        idx         <= bus.index_in;
                        base        <= '0;
                        state       <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    rsp_index_q <= '0;
                    rsp_data_q  <= '0;
                    rsp_hit_q   <= 1'b0;
                    case (op)
                        CMD_CLEAR: begin
                            fill        <= '0;
                            rsp_q       <= RSP_CLEARED;
                            rsp_valid_q <= 1'b1;
                            state       <= ST_RESP;
                        end
                        CMD_DECOMPRESS: begin
                            if ({1'b0, idx} < fill) begin
                                rsp_q      <= RSP_DECOMPRESSED;
                                rsp_data_q <= mem[idx];
                            end else begin
                                rsp_q <= RSP_ERROR;
                            end
                            rsp_valid_q <= 1'b1;
                            state       <= ST_RESP;
                        end
                        CMD_COMPRESS: begin
                            if (hit) begin
                                rsp_q       <= RSP_COMPRESSED;
                                rsp_hit_q   <= 1'b1;
                                rsp_index_q <= match_addr;
                                rsp_valid_q <= 1'b1;
                                state       <= ST_RESP;
                            end else if (last_group) begin
                                if (!full) begin
                                    rsp_q       <= RSP_COMPRESSED;
                                    rsp_index_q <= fill[IDX_W-1:0];
                                    fill        <= fill + 1'b1;
                                end else begin
                                    rsp_q <= RSP_ERROR;
                                end
                                rsp_valid_q <= 1'b1;
                                state       <= ST_RESP;
                            end else begin
                                base <= base + (IDX_W+1)'(LANES);
                            end
                        end
                        default: begin
                            rsp_q       <= RSP_ERROR;
                            rsp_valid_q <= 1'b1;
                            state       <= ST_RESP;
                        end
                    endcase
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp        = rsp_q;
    assign bus.rsp_index  = rsp_index_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.fill_count = fill;
    assign dbg_state      = state;
endmodule

// File: tb/tb_dict_codec.sv
// Bench for dict_codec (DATA_W=80, DEPTH=8, LANES=2): directed scenarios plus random
// traffic against a queue-based dictionary model, with a scoreboard monitor.
module tb_dict_codec;
    import dict_codec_pkg::*;

    localparam int DATA_W = 80;
    localparam int DEPTH  = 8;
    localparam int LANES  = 2;
    localparam int IDX_W  = 3;

    typedef struct packed {
        logic [1:0]        rsp;
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
        logic              hit;
        logic [IDX_W:0]    fill;
        logic [7:0]        lat;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset;
    state_e dbg_state;
    always #5 clk = ~clk;

    dict_codec_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    dict_codec #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    exp_t              exp_q[$];
    logic [DATA_W-1:0] model[$];
    logic [DATA_W-1:0] pool[6];
    logic [DATA_W-1:0] words[8];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    bit bp_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    // Scoreboard monitor
    exp_t cur;
    bit   in_rsp = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            in_rsp = 1'b0;
        end else if (bus.rsp_valid) begin
            if (!in_rsp) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=rsp_valid required=no response at cycle %0d", cyc);
                end else begin
                    cur    = exp_q.pop_front();
                    in_rsp = 1'b1;
                    check("latency", 128'(cyc - accept_cyc), 128'(cur.lat));
                end
            end
            if (in_rsp) begin
                check("rsp",        128'(bus.rsp),        128'(cur.rsp));
                check("rsp_index",  128'(bus.rsp_index),  128'(cur.index));
                check("rsp_data",   128'(bus.rsp_data),   128'(cur.data));
                check("rsp_hit",    128'(bus.rsp_hit),    128'(cur.hit));
                check("fill_count", 128'(bus.fill_count), 128'(cur.fill));
                if (bus.rsp_ready) in_rsp = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model at the dictionary level: a list of stored words.
    task automatic issue(input logic [1:0] c, input logic [DATA_W-1:0] d,
                         input logic [IDX_W-1:0] ix, input bit expect_rsp);
        exp_t e;
        int n;
        int h;
        n = 0;
        while (!bus.cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout actual=0 required=1 at cycle %0d", cyc);
            return;
        end
        e = '0;
        e.lat = 8'd1;
        n = model.size();
        case (c)
            2'b00: model.delete();
            2'b01: begin
                h = -1;
                for (int i = 0; i < n; i++) if (h < 0 && model[i] == d) h = i;
                if (h >= 0) begin
                    e.rsp = 2'b01; e.hit = 1'b1; e.index = IDX_W'(h);
                    e.lat = 8'(h / LANES + 1);
                end else begin
                    e.lat = (n == 0) ? 8'd1 : 8'((n + LANES - 1) / LANES);
                    if (n < DEPTH) begin
                        e.rsp = 2'b01; e.index = IDX_W'(n);
                        model.push_back(d);
                    end else begin
                        e.rsp = 2'b11;
                    end
                end
            end
            2'b10: begin
                if (int'(ix) < n) begin
                    e.rsp = 2'b10; e.data = model[ix];
                end else begin
                    e.rsp = 2'b11;
                end
            end
            default: e.rsp = 2'b11;
        endcase
        e.fill = (IDX_W+1)'(model.size());
        if (expect_rsp) exp_q.push_back(e);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.data_in   = d;
        bus.index_in  = ix;
        @(posedge clk); #1;
        accept_cyc    = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_rsp || !bus.cmd_ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 128'(n < 300), 128'(1));
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.data_in   = '0;
        bus.index_in  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", 128'(bus.cmd_ready),  128'(0));
        check("reset_rsp_valid", 128'(bus.rsp_valid),  128'(0));
        check("reset_rsp",       128'(bus.rsp),        128'(0));
        check("reset_rsp_index", 128'(bus.rsp_index),  128'(0));
        check("reset_rsp_data",  128'(bus.rsp_data),   128'(0));
        check("reset_rsp_hit",   128'(bus.rsp_hit),    128'(0));
        check("reset_fill",      128'(bus.fill_count), 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_cmd_ready", 128'(bus.cmd_ready), 128'(1));

        issue(2'b10, '0, 3'd0, 1'b1);
        issue(2'b01, '0, 3'd0, 1'b1);
        issue(2'b01, '0, 3'd0, 1'b1);

        issue(2'b00, '0, 3'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            words[i] = rand_word();
            words[i][3:0] = 4'(i);
            issue(2'b01, words[i], 3'd0, 1'b1);
        end
        begin
            logic [DATA_W-1:0] b;
            b = rand_word();
            b[3:0] = 4'd8;
            issue(2'b01, b, 3'd0, 1'b1);
        end
        issue(2'b01, words[7], 3'd0, 1'b1);
        issue(2'b10, '0, 3'd5, 1'b1);
        issue(2'b11, '0, 3'd0, 1'b1);

        // Backpressure hold: response must stay put and no command is taken.
        wait_done();
        bus.rsp_ready = 1'b0;
        issue(2'b10, '0, 3'd3, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd       = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_cmd_ready", 128'(bus.cmd_ready), 128'(0));
            check("hold_rsp_valid", 128'(bus.rsp_valid), 128'(1));
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;

        issue(2'b00, '0, 3'd0, 1'b1);
        issue(2'b10, '0, 3'd5, 1'b1);

        for (int i = 0; i < 6; i++) begin
            pool[i] = (i == 0) ? '0 : rand_word();
        end
        wait_done();
        bp_en = 1'b1;
        for (int k = 0; k < 150; k++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 2)       issue(2'b00, '0, 3'd0, 1'b1);
            else if (r < 12) issue(2'b01, pool[$urandom_range(0, 5)], 3'd0, 1'b1);
            else if (r < 18) issue(2'b10, '0, 3'($urandom_range(0, 7)), 1'b1);
            else             issue(2'b11, rand_word(), 3'd0, 1'b1);
        end
        bp_en = 1'b0;
        @(posedge clk); #2;
        bus.rsp_ready = 1'b1;
        wait_done();

        // Reset in the middle of a search for a new word at fill_count=6.
        issue(2'b00, '0, 3'd0, 1'b1);
        for (int i = 0; i < 6; i++) issue(2'b01, words[i], 3'd0, 1'b1);
        issue(2'b01, words[6], 3'd0, 1'b0);
        @(posedge clk); #1;
        check("mid_search_state", 128'(dbg_state), 128'(ST_SEARCH));
        reset = 1'b1;
        model.delete();
        #1;
        check("abort_rsp_valid", 128'(bus.rsp_valid),  128'(0));
        check("abort_fill",      128'(bus.fill_count), 128'(0));
        check("abort_cmd_ready", 128'(bus.cmd_ready),  128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post_abort_fill", 128'(bus.fill_count), 128'(0));
        issue(2'b10, '0, 3'd0, 1'b1);
        issue(2'b01, words[6], 3'd0, 1'b1);
        wait_done();
        check("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
